filter_enum: RTL and testbench

- Full Crypto1 filter-function preimage enumerator. It sits directly upstream of the LFSR state-candidate recovery logic.
- Given one keystream bit, it walks every 20-bit filter input (five nibbles) for which fc(fa, fb, fb, fa, fb) equals that bit.
- Candidates are emitted one per accepted handshake, in a fixed deterministic order.
- It replaces the free-running per-nibble enumerators with a single start/valid/ready sequencer.

---
 rtl/filter_enum_if.sv | 34 +++
 rtl/filter_enum.sv | 182 ++++++++++++++++++
 tb/tb_filter_enum.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_enum_if.sv
// filter_enum_if -- handshake bundle between the Crypto1 filter preimage
// enumerator and its consumer.
//   start  : begin a run (taken only while the enumerator is idle)
//   ks_bit : target filter output, latched when start is taken
//   ready  : consumer accepts cand when valid & ready
//   valid  : cand holds a candidate
//   cand   : 20-bit filter input, nibble k = cand[4k+3:4k]
//   index  : ordinal of cand within the run, 0..524287
//   last   : final candidate of the run (qualified by valid)
//   busy   : a run is in progress
//   done   : one-cycle pulse after the final candidate is accepted
// The slave modport is the enumerator; the master modport is the producer
// of start/ks_bit and consumer of candidates.
interface filter_enum_if;
  logic        start;
  logic        ks_bit;
  logic        ready;
  logic        valid;
  logic [19:0] cand;
  logic [18:0] index;
  logic        last;
  logic        busy;
  logic        done;

  modport master (
    output start, ks_bit, ready,
    input  valid, cand, index, last, busy, done
  );

  modport slave (
    input  start, ks_bit, ready,
    output valid, cand, index, last, busy, done
  );
endinterface

// File: rtl/filter_enum.sv
// filter_enum -- Crypto1 filter-function preimage enumerator.
// Given one keystream bit, walks every 20-bit filter input whose
// fc(fa, fb, fb, fa, fb) output equals that bit, one candidate per accepted
// handshake, in a fixed order:
//   outer: qualifying fc patterns n in ascending order (16 of them)
//   inner: five 3-bit digits d0..d4 (d0 fastest); nibble k is the d_k-th
//          ascending 4-bit input whose sub-function output equals n[k].
// Because 16 patterns x 8^5 digits = 2^19, the run ordinal itself encodes the
// position: index[18:15] selects the pattern, index[3k+2:3k] is digit d_k.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, aborts any run without done
//   bus   : filter_enum_if.slave handshake bundle (see interface header)
// All outputs are registered; ready/start reach outputs only through flops.
module filter_enum #(
  parameter logic [15:0] FA_FN = 16'h9E98,
  parameter logic [15:0] FB_FN = 16'hB48E,
  parameter logic [31:0] FC_FN = 32'hEC57E80A
) (
  input  logic         clk,
  input  logic         rst_n,
  filter_enum_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Ordinal-th fc input (ascending) whose table entry equals ks.
  function automatic logic [4:0] nth_pattern(input logic [3:0] ord, input logic ks);
    logic [4:0] res;
    logic [4:0] cnt;
    res = 5'd0;
    cnt = 5'd0;
    for (int n = 0; n < 32; n++) begin
      if (FC_FN[n] == ks) begin
        if (cnt == {1'b0, ord}) begin
          res = 5'(n);
        end
        cnt = cnt + 5'd1;
      end
    end
    return res;
  endfunction

  // d-th 4-bit input (ascending) for which fn produces want.
  function automatic logic [3:0] nth_input(input logic [15:0] fn, input logic want,
                                           input logic [2:0] d);
    logic [3:0] res;
    logic [3:0] cnt;
    res = 4'd0;
    cnt = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (fn[i] == want) begin
        if (cnt == {1'b0, d}) begin
          res = 4'(i);
        end
        cnt = cnt + 4'd1;
      end
    end
    return res;
  endfunction

  // Candidate at a given run ordinal; nibbles 0 and 3 feed fa, the rest fb.
  function automatic logic [19:0] build_cand(input logic [18:0] idx, input logic ks);
    logic [4:0]  n;
    logic [19:0] c;
    n        = nth_pattern(idx[18:15], ks);
    c[3:0]   = nth_input(FA_FN, n[0], idx[2:0]);
    c[7:4]   = nth_input(FB_FN, n[1], idx[5:3]);
    c[11:8]  = nth_input(FB_FN, n[2], idx[8:6]);
    c[15:12] = nth_input(FA_FN, n[3], idx[11:9]);
    c[19:16] = nth_input(FB_FN, n[4], idx[14:12]);
    return c;
  endfunction

  state_t      state_r, state_next;
  logic        ks_r, ks_next;
  logic [18:0] index_r, index_next;
  logic [19:0] cand_r, cand_next;
  logic        last_r, last_next;
  logic        valid_r, valid_next;
  logic        busy_r, busy_next;
  logic        done_r, done_next;

  // One shared candidate builder: from IDLE it produces ordinal 0 for the
  // incoming ks_bit, during a run it produces the successor of the current one.
  logic [18:0] step_idx;
  logic        step_ks;
  logic [19:0] step_cand;
  logic        accept;

  assign step_idx  = (state_r == IDLE) ? 19'd0 : (index_r + 19'd1);
  assign step_ks   = (state_r == IDLE) ? bus.ks_bit : ks_r;
  assign step_cand = build_cand(step_idx, step_ks);
  assign accept    = valid_r & bus.ready;

  // Next-state and next-output logic for the start/valid/ready sequencer.
  always_comb begin
    state_next = state_r;
    ks_next    = ks_r;
    index_next = index_r;
    cand_next  = cand_r;
    last_next  = last_r;
    valid_next = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
          ks_next    = bus.ks_bit;
          index_next = step_idx;
          cand_next  = step_cand;
          last_next  = 1'b0;
          valid_next = 1'b1;
          busy_next  = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        valid_next = 1'b1;
        busy_next  = 1'b1;
        if (accept && last_r) begin
          state_next = FIN;
          valid_next = 1'b0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          last_next  = 1'b0;
        end else if (accept) begin
          index_next = step_idx;
          cand_next  = step_cand;
          last_next  = (step_idx == {19{1'b1}});
        end else begin
          // stalled: candidate, ordinal and last are held
          state_next = RUN;
        end
      end
      FIN: begin
        // start is deliberately not looked at in the done cycle
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything so an aborted run emits no done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ks_r    <= 1'b0;
      index_r <= 19'd0;
      cand_r  <= 20'd0;
      last_r  <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next;
      ks_r    <= ks_next;
      index_r <= index_next;
      cand_r  <= cand_next;
      last_r  <= last_next;
      valid_r <= valid_next;
      busy_r  <= busy_next;
      done_r  <= done_next;
    end
  end

  assign bus.valid = valid_r;
  assign bus.cand  = cand_r;
  assign bus.index = index_r;
  assign bus.last  = last_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_filter_enum.sv
// tb_filter_enum -- directed self-checking bench for filter_enum.
// Expected candidates come from hand-derived sorted preimage lists of fa/fb
// and the hand-derived qualifying fc patterns; each candidate is also pushed
// back through the fa/fb/fc truth tables to confirm it yields the run's bit.
// Long stretches of a run are skipped by forcing the ordinal register while
// the consumer stalls, so the pattern wrap, last and done paths are reached
// in a few thousand cycles.
module tb_filter_enum;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  filter_enum_if bus ();

  filter_enum dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] FA = 16'h9E98;
  localparam logic [15:0] FB = 16'hB48E;
  localparam logic [31:0] FC = 32'hEC57E80A;

  // Sorted preimages of each sub-function output value.
  localparam int FA0[8]   = '{0, 1, 2, 5, 6, 8, 13, 14};
  localparam int FA1[8]   = '{3, 4, 7, 9, 10, 11, 12, 15};
  localparam int FB0[8]   = '{0, 4, 5, 6, 8, 9, 11, 14};
  localparam int FB1[8]   = '{1, 2, 3, 7, 10, 12, 13, 15};
  // fc inputs producing 0 and 1, ascending.
  localparam int PAT0[16] = '{0, 2, 4, 5, 6, 7, 8, 9, 10, 12, 19, 21, 23, 24, 25, 28};
  localparam int PAT1[16] = '{1, 3, 11, 13, 14, 15, 16, 17, 18, 20, 22, 26, 27, 29, 30, 31};

  int   checks    = 0;
  int   errors    = 0;
  int   exp_idx   = 0;
  logic run_ks    = 1'b0;
  int   done_cnt  = 0;
  int   done_base = 0;
  bit   seen [int];

  // Count done pulses as seen between clock edges.
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] model_cand(input int idx, input logic ks);
    int p;
    int n;
    int d;
    int v;
    logic [19:0] c;
    p = (idx >> 15) & 15;
    n = ks ? PAT1[p] : PAT0[p];
    c = 20'h00000;
    for (int k = 0; k < 5; k++) begin
      d = (idx >> (3 * k)) & 7;
      if (k == 0 || k == 3) v = n[k] ? FA1[d] : FA0[d];
      else                  v = n[k] ? FB1[d] : FB0[d];
      c[4*k +: 4] = v[3:0];
    end
    return c;
  endfunction

  function automatic logic eval_ks(input logic [19:0] c);
    logic [4:0] n;
    n[0] = FA[c[3:0]];
    n[1] = FB[c[7:4]];
    n[2] = FB[c[11:8]];
    n[3] = FA[c[15:12]];
    n[4] = FB[c[19:16]];
    return FC[n];
  endfunction

  task automatic check_cand();
    check("valid", 32'(bus.valid), 32'd1);
    check("index", 32'(bus.index), 32'(exp_idx));
    check("cand", 32'(bus.cand), 32'(model_cand(exp_idx, run_ks)));
    check("last", 32'(bus.last), (exp_idx == 524287) ? 32'd1 : 32'd0);
    check("ks_eval", 32'(eval_ks(bus.cand)), 32'(run_ks));
    check("dup", seen.exists(int'(bus.cand)) ? 32'd1 : 32'd0, 32'd0);
  endtask

  // Entered just after a falling edge: check the shown candidate, drive ready.
  task automatic cand_step(input logic rdy);
    check_cand();
    bus.ready = rdy;
    if (rdy) begin
      seen[int'(bus.cand)] = 1'b1;
      exp_idx++;
    end
    @(negedge clk);
  endtask

  task automatic start_run(input logic ks);
    bus.start  = 1'b1;
    bus.ks_bit = ks;
    bus.ready  = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    run_ks    = ks;
    exp_idx   = 0;
    seen.delete();
    done_base = done_cnt;
    check("busy_run", 32'(bus.busy), 32'd1);
  endtask

  // Jump the run forward: stall, overwrite the ordinal, then accept the stale
  // candidate so the next one is built from the new ordinal.
  task automatic jump(input int target);
    bus.ready = 1'b0;
    force dut.index_r = 19'(target);
    @(negedge clk);
    release dut.index_r;
    @(negedge clk);
    check("jump_index", 32'(bus.index), 32'(target));
    bus.ready = 1'b1;
    @(negedge clk);
    exp_idx = target + 1;
  endtask

  // Entered in the done cycle; start pulsed here must be ignored.
  task automatic finish_run(input logic try_ks);
    check("done_pulse", 32'(bus.done), 32'd1);
    check("valid_fin", 32'(bus.valid), 32'd0);
    check("busy_fin", 32'(bus.busy), 32'd0);
    bus.start  = 1'b1;
    bus.ks_bit = try_ks;
    bus.ready  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("done_once", 32'(done_cnt - done_base), 32'd1);
    check("idle_valid", 32'(bus.valid), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    check("still_idle", 32'(bus.valid), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start  = 1'b0;
    bus.ks_bit = 1'b0;
    bus.ready  = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_last", 32'(bus.last), 32'd0);
    check("rst_cand", 32'(bus.cand), 32'd0);
    check("rst_index", 32'(bus.index), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- run with ks_bit = 0 ----------------
    start_run(1'b0);
    check("ks0_c0", 32'(bus.cand), 32'h00000);
    cand_step(1'b1);
    check("ks0_c1", 32'(bus.cand), 32'h00001);
    cand_step(1'b1);
    check("ks0_c2", 32'(bus.cand), 32'h00002);
    repeat (40) cand_step(1'b1);
    // start and a different ks_bit while busy change nothing
    bus.start  = 1'b1;
    bus.ks_bit = 1'b1;
    repeat (5) cand_step(1'b1);
    bus.start = 1'b0;
    repeat (200) cand_step(1'($urandom_range(0, 1)));

    // fc-pattern wrap with a 10-cycle stall on the last candidate of n=0
    jump(32760);
    while (exp_idx < 32767) cand_step(1'b1);
    check("prewrap_cand", 32'(bus.cand), 32'hEEEEE);
    repeat (10) cand_step(1'b0);
    cand_step(1'b1);
    check("wrap_index", 32'(bus.index), 32'd32768);
    check("wrap_cand", 32'(bus.cand), 32'h00010);
    repeat (60) cand_step(1'($urandom_range(0, 1)));

    // end of run
    jump(524272);
    while (exp_idx < 524287) cand_step(1'($urandom_range(0, 1)));
    check("ks0_final", 32'(bus.cand), 32'hFFFEE);
    check("ks0_last", 32'(bus.last), 32'd1);
    cand_step(1'b1);
    finish_run(1'b1);

    // ---------------- run with ks_bit = 1 ----------------
    start_run(1'b1);
    check("ks1_c0", 32'(bus.cand), 32'h00003);
    bus.ks_bit = 1'b0;
    while (exp_idx < 8) cand_step(1'b1);
    check("ks1_c8", 32'(bus.cand), 32'h00043);
    while (exp_idx < 1000) cand_step(1'b1);
    check_cand();

    // asynchronous abort mid-run
    bus.ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(bus.valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_cand", 32'(bus.cand), 32'd0);
    check("abort_index", 32'(bus.index), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_done", 32'(done_cnt - done_base), 32'd0);
    check("abort_idle", 32'(bus.valid), 32'd0);

    start_run(1'b1);
    check("restart_index", 32'(bus.index), 32'd0);
    check("restart_cand", 32'(bus.cand), 32'h00003);
    repeat (20) cand_step(1'($urandom_range(0, 1)));
    jump(524286);
    check("ks1_final", 32'(bus.cand), 32'hFFFFF);
    check("ks1_last", 32'(bus.last), 32'd1);
    cand_step(1'b0);
    cand_step(1'b1);
    finish_run(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
